// File: rtl/rob_commit_if.sv
// rtl/rob_commit_if.sv - rename/complete/commit signal bundle between the ROB and its neighbours
interface rob_commit_if;
  logic [19:0] rob_entries_out;
  logic        rob_alloc_ready;
  logic        alloc_valid;
  logic [31:0] alloc_arch_regs;
  logic [39:0] alloc_old_aliases;
  logic [4:0]  exec_cmplt_valid;
  logic [24:0] exec_cmplt_idx;
  logic [29:0] cmplt_free_regs;
  logic [1:0]  commit_count;
  logic [5:0]  rob_count;
  logic [31:0] commit_total;

  // Decoder/execution side: drives allocation and completions, observes commits.
  modport master (
    input  rob_entries_out, rob_alloc_ready, cmplt_free_regs,
           commit_count, rob_count, commit_total,
    output alloc_valid, alloc_arch_regs, alloc_old_aliases,
           exec_cmplt_valid, exec_cmplt_idx
  );

  // ROB side.
  modport slave (
    output rob_entries_out, rob_alloc_ready, cmplt_free_regs,
           commit_count, rob_count, commit_total,
    input  alloc_valid, alloc_arch_regs, alloc_old_aliases,
           exec_cmplt_valid, exec_cmplt_idx
  );
endinterface

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order reorder buffer with 4-wide allocate and 3-wide commit (optional ROB_COMMIT_STATS_EN)
module rob_commit (
  input  logic         clk,
  input  logic         rst,
  rob_commit_if.slave  bus
);
  localparam int DEPTH    = 32;
  localparam int ALLOC_W  = 4;
  localparam int CMPL_W   = 5;
  localparam int COMMIT_W = 3;

  logic [4:0]              head_q, head_d;
  logic [4:0]              tail_q, tail_d;
  logic [5:0]              count_q, count_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        done_q, done_d;
  logic [DEPTH-1:0][7:0]   arch_q;
  logic [DEPTH-1:0][9:0]   old_q;
  logic [29:0]             free_q, free_d;
  logic [1:0]              commit_count_q;
  logic [1:0]              commit_k;
  logic                    alloc_fire;
  logic                    ready;
  logic                    ok0, ok1, ok2;

  // Arch mappings are held per entry for recovery/debug visibility; nothing in this block reads them.
  logic unused_arch;
  assign unused_arch = ^arch_q;

  // Ready uses registered count only, so a same-cycle commit never opens false room.
  assign ready      = (count_q <= 6'(DEPTH - ALLOC_W));
  assign alloc_fire = bus.alloc_valid & ready;

  assign bus.rob_alloc_ready = ready;
  assign bus.rob_count       = count_q;
  assign bus.rob_entries_out = {tail_q + 5'd3, tail_q + 5'd2, tail_q + 5'd1, tail_q};
  assign bus.cmplt_free_regs = free_q;
  assign bus.commit_count    = commit_count_q;

  // Retire width: run of valid & done entries from head, capped at three, from registered flags.
  always_comb begin
    ok0 = valid_q[head_q]         & done_q[head_q];
    ok1 = valid_q[head_q + 5'd1]  & done_q[head_q + 5'd1];
    ok2 = valid_q[head_q + 5'd2]  & done_q[head_q + 5'd2];
    commit_k = 2'd0;
    if (ok0) begin
      commit_k = 2'd1;
      if (ok1) begin
        commit_k = 2'd2;
        if (ok2) commit_k = 2'd3;
      end
    end
  end

  // Next-state for flags, pointers, count and the free-alias bus.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    free_d  = '0;
    for (int p = 0; p < CMPL_W; p++) begin
      if (bus.exec_cmplt_valid[p] && valid_q[bus.exec_cmplt_idx[5*p +: 5]])
        done_d[bus.exec_cmplt_idx[5*p +: 5]] = 1'b1;
    end
    for (int j = 0; j < COMMIT_W; j++) begin
      if (2'(j) < commit_k) begin
        valid_d[head_q + 5'(j)] = 1'b0;
        done_d[head_q + 5'(j)]  = 1'b0;
        free_d[10*j +: 10]      = old_q[head_q + 5'(j)];
      end
    end
    // Ready guarantees at least four free slots, so these never overlap retiring entries.
    if (alloc_fire) begin
      for (int i = 0; i < ALLOC_W; i++) begin
        valid_d[tail_q + 5'(i)] = 1'b1;
        done_d[tail_q + 5'(i)]  = 1'b0;
      end
    end
    head_d  = head_q + {3'd0, commit_k};
    tail_d  = tail_q + (alloc_fire ? 5'd4 : 5'd0);
    count_d = count_q + (alloc_fire ? 6'd4 : 6'd0) - {4'd0, commit_k};
  end

  // Control state and registered commit outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      free_q         <= '0;
      commit_count_q <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      free_q         <= free_d;
      commit_count_q <= commit_k;
    end
  end

  // Per-entry payload; only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      for (int i = 0; i < ALLOC_W; i++) begin
        arch_q[tail_q + 5'(i)] <= bus.alloc_arch_regs[8*i +: 8];
        old_q[tail_q + 5'(i)]  <= bus.alloc_old_aliases[10*i +: 10];
      end
    end
  end

`ifdef ROB_COMMIT_STATS_EN
  logic [31:0] commit_total_q;

  // Wrapping count of retired instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) commit_total_q <= '0;
    else     commit_total_q <= commit_total_q + {30'd0, commit_k};
  end

  assign bus.commit_total = commit_total_q;
`else
  assign bus.commit_total = 32'd0;
`endif

endmodule

// File: doc/rob_commit.md
# rob_commit

In-order reorder buffer and commit unit: the retirement end of the rename protocol driven by the 4-wide decoder. It hands the decoder four free ROB indices per rename batch and records each batch's arch-reg mapping and old physical aliases. It marks entries done from execution completions, retires up to three instructions per cycle in program order, and returns the retired instructions' old aliases to the decoder's free pool on `cmplt_free_regs`.

## Interface
- `DEPTH`, 32: ROB entries; fixed by the 5-bit ROB index.
- `ALLOC_W`, 4: entries allocated per batch; equals decoder WIDTH.
- `CMPL_W`, 5: execution completion ports.
- `COMMIT_W`, 3: max retirements per cycle (3 × 2 aliases × 5 bits = 30-bit free-reg bus).

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rob_entries_out`  out  20  four indices {tail+3, tail+2, tail+1, tail} mod 32; slot i at [5i+:5].
- `rob_alloc_ready`  out  1  high when count ≤ 28.
- `alloc_valid`  in  1  one-cycle pulse per rename batch; driven by decoder `old_aliases_valid`.
- `alloc_arch_regs`  in  32  per slot, 8 bits = two 4-bit arch dest regs.
- `alloc_old_aliases`  in  40  per slot, 10 bits = two 5-bit previous phys aliases.
- `exec_cmplt_valid`  in  5  per-port completion strobe.
- `exec_cmplt_idx`  in  25  per-port ROB index, port p at [5p+:5].
- `cmplt_free_regs`  out  30  registered; old aliases of instructions retired last cycle; slot j at [10j+:10]; unused slots 0.
- `commit_count`  out  2  registered; number retired last cycle (0–3).
- `rob_count`  out  6  occupied entries (0–32).
- `commit_total`  out  32  retired-instruction counter; see Configuration.

## Operation
- State: `head`, `tail` (5-bit, wrap mod 32), `count` (6-bit). Per entry: `valid`, `done`, `arch[7:0]`, `old[9:0]`.
- **Allocate.** Occurs when `alloc_valid & rob_alloc_ready`.
  - Slot i writes entry tail+i with valid=1, done=0, its arch and old fields.
  - tail += 4.
- **Allocate while not ready.** `alloc_valid` with `rob_alloc_ready`=0 is dropped with no state change. It is a protocol violation; the bench asserts on it. Upstream gates decoder acceptance on `rob_alloc_ready`.
- **Complete.** Each strobed port sets `done` on its entry.
  - An index with valid=0 is ignored.
  - Duplicate indices in one cycle are harmless.
- **Commit.** k = count of consecutive entries from head with valid & done, capped at 3, using registered flags only.
  - Those k entries clear to valid=0 and head += k.
  - Next cycle `cmplt_free_regs` slot j = old[head+j] for j<k, and 0 otherwise.
  - Alias values 0/1 are passed through unchanged; the decoder ignores values ≤1.
- **Simultaneous allocate and commit.** count_next = count + 4·alloc − k.
  - `rob_alloc_ready` comes from registered count, so a same-cycle commit never creates false room.
  - Allocation cannot overwrite entries being committed: ready implies ≥4 free entries.
- **Completion to head in the same cycle.** Not committed that cycle; commits no earlier than the next cycle.
- **Full/empty.**
  - count=32: ready=0, tail==head.
  - count=0: k=0, outputs 0.

## Timing
- Reset (async assert) values:
  - head=tail=0, count=0, all valid/done=0.
  - `cmplt_free_regs`=0, `commit_count`=0, `commit_total`=0.
  - `rob_alloc_ready`=1, `rob_entries_out`={3,2,1,0}.
- Deassertion is synchronous to `clk` externally. Reset mid-operation discards all entries; nothing is returned to the free pool.
- `rob_entries_out` and `rob_alloc_ready` are combinational from registers and stable all cycle. Indices latched by the decoder remain valid until the matching `alloc_valid`, because tail only moves on allocation.
- Latencies:
  - Completion to earliest commit: 1 cycle.
  - Commit to `cmplt_free_regs`: 1 cycle (registered).
  - Allocation to entry visible for completion: next cycle.

## Configuration
- `ROB_COMMIT_STATS_EN` defined: `commit_total` is a 32-bit wrapping counter, incremented by k each cycle.
- Not defined: `commit_total` is tied to 0 and no counter is synthesized; the port remains.

## Test plan
- Reset, then single batch:
  - Reset → entries {3,2,1,0}, ready=1.
  - Allocate with old aliases 5/6, 7/8, 9/10, 11/12 → rob_count=4, `rob_entries_out`={7,6,5,4}.
- In-order commit: complete idx 0,1,2,3 together → commit_count=3 with free regs {10/9 at slot 2, 8/7, 6/5} one cycle later, then commit_count=1 (slot 0 = 12/11).
- Out-of-order completion blocks: complete idx 1,2 only → commit_count=0. Then complete idx 0 → commit_count=3 in the cycle after.
- Full boundary:
  - 8 allocations → count=32, ready=0. An extra `alloc_valid` is dropped, count stays 32.
  - Commit 3 → ready stays 0 while count=29.
  - At count=28 → ready=1.
- Wrap-around: cycle tail past 31 → `rob_entries_out`={1,0,31,30} when tail=30; commits across index 31→0 are in order.
- Simultaneous allocate and commit: count=8, alloc + 3 commits in one cycle → count=9. Async reset asserted mid-run → all outputs 0 immediately, entries {3,2,1,0}.
